env_multiplier: RTL and testbench
=================================

# env_multiplier

Sequential shift-add multiplier that responds to the envelope generator's multiply handshake. It scales a signed 12-bit voice waveform sample by the unsigned 8-bit envelope level and returns a 12-bit scaled sample. It also accumulates the three scaled voices of one sample frame into a mix word for the downstream filter/output stage. It sits between the waveform generators, the envelope generator and the mixer/filter path.

## Interface

Parameters:
- None. Widths are fixed: wave 12, env 8, product 20, mix 14.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- start_i  in  1  multiply request from the envelope generator; a one-cycle pulse.
- voice_idx_i  in  2  voice being processed (0–2); sampled with start_i.
- wave_i  in  12  signed two's-complement waveform sample; sampled with start_i.
- env_i  in  8  unsigned envelope level; sampled with start_i.
- ready_o  out  1  one-cycle pulse; the result is valid. Drives the envelope generator's multiply-ready input.
- prod_o  out  12  signed scaled sample, (wave × env) >> 8.
- mix_o  out  14  signed sum of the three scaled voices of the last completed frame.
- mix_valid_o  out  1  one-cycle pulse; mix_o was updated.

## Operation

State machine states and transitions:
- IDLE → CALC when start_i = 1. In the same edge, latch wave_i (sign-extended to 20 bits), env_i, voice_idx_i, clear the 20-bit accumulator and clear the 3-bit bit counter.
- CALC: each cycle processes env bit k = counter. If that bit is 1, add (wave << k) to the accumulator. Then increment the counter. After k = 7 the state goes to DONE (exactly 8 CALC cycles).
- DONE: ready_o = 1. prod_o ← acc[19:8]. Next state is IDLE.
- start_i is ignored in CALC and DONE; no queueing.

Arithmetic:
- The full product range −522240 to +521985 fits the 20-bit signed accumulator. Overflow cannot occur.
- prod_o is an arithmetic right shift (floor toward −∞), with no rounding. prod_o range is −2040 to +2039.

Mix accumulation, performed on the DONE cycle edge:
- If latched voice = 0: mix_acc ← sext14(prod).
- If latched voice = 1 or 2: mix_acc ← mix_acc + sext14(prod).
- If latched voice = 2: additionally mix_o ← the new sum and mix_valid_o ← 1 for one cycle.
- If latched voice = 3: prod_o and ready_o behave normally. mix_acc, mix_o and mix_valid_o are untouched.
- The 14-bit range ±8191 covers the worst case 3 × ±2040, so the mix never saturates.
- A frame missing voice 0 simply continues the prior sum. No frame-tracking error is flagged.

## Timing

- Reset values: state IDLE; ready_o, mix_valid_o = 0; prod_o, mix_o, mix_acc, accumulator and counter = 0.
- Latency, with start_i high in cycle T:
  - CALC during T+1 … T+8.
  - ready_o high in T+9 only.
  - prod_o is updated at the end of T+9 and holds until the next DONE.
  - mix_o and mix_valid_o are updated at the end of T+9; mix_valid_o is high in T+10 only.
- Fixed 10-cycle turnaround. The earliest accepted next start_i is in cycle T+10.
- Operands are captured only at start. Changes on wave_i, env_i or voice_idx_i afterwards have no effect on the current result.
- Reset mid-operation (CALC or DONE): return to IDLE immediately. No ready_o pulse is issued and the partial result is discarded. Outputs return to their reset values.
- env_i = 0 → prod_o = 0. env_i = 255 → near full scale, never exact unity.

## Test plan

- Reset, then check all outputs are 0. wave=2047, env=255, voice=0, start pulse → ready_o exactly at T+9, prod_o = 2039. No mix_valid_o.
- wave=−2048, env=255 → prod_o = −2040. wave=−1, env=1 → prod_o = −1 (floor). wave=1000, env=0 → prod_o = 0.
- Frame test: voice0 wave=1024/env=128 (prod 512), voice1 wave=−512/env=255 (prod −510), voice2 wave=2047/env=64 (prod 511) → mix_valid_o one pulse at T+10 of voice2, mix_o = 513. Next frame voice0 restarts the sum.
- start_i re-pulsed during CALC, and wave_i/env_i toggled during CALC → ignored. Single ready_o with the original operands' result.
- Assert rst_ni at CALC cycle 4 → no ready_o, all outputs 0. A fresh start afterwards completes normally in 10 cycles.
- Voice 3 request between voice1 and voice2 → ready_o and prod_o valid. Mix sum unaffected (same mix_o as the frame test).

Source files
------------

// File: rtl/env_multiplier_if.sv
// Multiply handshake between the envelope generator (master) and the
// shift-add voice multiplier (slave), plus the frame mix result.
interface env_multiplier_if;
    logic               start_i;
    logic [1:0]         voice_idx_i;
    logic signed [11:0] wave_i;
    logic [7:0]         env_i;
    logic               ready_o;
    logic signed [11:0] prod_o;
    logic signed [13:0] mix_o;
    logic               mix_valid_o;

    modport master (
        output start_i, voice_idx_i, wave_i, env_i,
        input  ready_o, prod_o, mix_o, mix_valid_o
    );

    modport slave (
        input  start_i, voice_idx_i, wave_i, env_i,
        output ready_o, prod_o, mix_o, mix_valid_o
    );
endinterface

// File: rtl/env_multiplier.sv
// Sequential shift-add multiplier: signed 12-bit wave x unsigned 8-bit envelope,
// scaled by 1/256, with per-frame accumulation of voices 0..2 into a mix word.
module env_multiplier (
    input  logic             clk_i,
    input  logic             rst_ni,
    env_multiplier_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e             state_q, state_d;
    logic signed [19:0] wave_q;
    logic signed [19:0] acc_q;
    logic [7:0]         env_q;
    logic [1:0]         voice_q;
    logic [2:0]         cnt_q;
    logic signed [11:0] prod_q;
    logic signed [13:0] mix_acc_q;
    logic signed [13:0] mix_q;
    logic               mix_valid_q;

    logic signed [11:0] prod_new;
    logic signed [13:0] prod_ext;
    logic signed [13:0] mix_sum;

    // NOTE: next-state defaults to the current state first, so no path leaves
    // state_d unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i) state_d = CALC;
            CALC:    if (cnt_q == 3'd7) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Arithmetic shift by 8 is just the top 12 bits of the 20-bit product.
    assign prod_new = acc_q[19:8];
    assign prod_ext = {{2{prod_new[11]}}, prod_new};
    assign mix_sum  = (voice_q == 2'd0) ? prod_ext : mix_acc_q + prod_ext;

    // NOTE: all state here is sequential and uses non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wave_q      <= '0;
            acc_q       <= '0;
            env_q       <= '0;
            voice_q     <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            mix_acc_q   <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
        end else begin
            mix_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        wave_q  <= {{8{bus.wave_i[11]}}, bus.wave_i};
                        env_q   <= bus.env_i;
                        voice_q <= bus.voice_idx_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                CALC: begin
                    if (env_q[cnt_q]) begin
                        acc_q <= acc_q + (wave_q <<< cnt_q);
                    end
                    cnt_q <= cnt_q + 3'd1;
                end
                DONE: begin
                    prod_q <= prod_new;
                    // Voice 3 produces a result but never touches the frame mix.
                    if (voice_q != 2'd3) begin
                        mix_acc_q <= mix_sum;
                    end
                    if (voice_q == 2'd2) begin
                        mix_q       <= mix_sum;
                        mix_valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_o     = (state_q == DONE);
    assign bus.prod_o      = prod_q;
    assign bus.mix_o       = mix_q;
    assign bus.mix_valid_o = mix_valid_q;

endmodule

// File: tb/tb_env_multiplier.sv
// Self-checking bench for env_multiplier: a reference model pushes expected
// products and frame mixes into queues that are popped when the DUT responds.
module tb_env_multiplier;

    logic clk_i;
    logic rst_ni;

    env_multiplier_if bus ();

    env_multiplier dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_prod_q[$];
    int exp_mix_q[$];
    int model_mix = 0;

    // Drives one request at the current negedge (cycle T) and collects the
    // response; returns at the negedge of T+10 so the next call starts there.
    task automatic run_op(input int voice, input int w, input int e, input bit disturb,
                          output int lat, output bit extra_ready, output bit early_mv,
                          output int prod, output bit mv, output int mix);
        int p;
        p = (w * e) >>> 8;
        exp_prod_q.push_back(p);
        if (voice == 0) model_mix = p;
        else if (voice < 3) model_mix = model_mix + p;
        if (voice == 2) exp_mix_q.push_back(model_mix);

        bus.start_i     = 1'b1;
        bus.voice_idx_i = 2'(voice);
        bus.wave_i      = 12'(w);
        bus.env_i       = 8'(e);
        lat      = 99;
        early_mv = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_i);
            if (bus.mix_valid_o) early_mv = 1'b1;
            if (bus.ready_o) begin
                lat = c;
                break;
            end
            if (c == 1) begin
                bus.start_i     = 1'b0;
                bus.wave_i      = 12'($urandom);
                bus.env_i       = 8'($urandom);
                bus.voice_idx_i = 2'($urandom);
            end
            if (disturb && c == 2) bus.start_i = 1'b1;
            if (disturb && c == 3) bus.start_i = 1'b0;
        end
        bus.start_i = 1'b0;
        @(negedge clk_i);
        extra_ready = bus.ready_o;
        prod        = bus.prod_o;
        mv          = bus.mix_valid_o;
        mix         = bus.mix_o;
    endtask

    task automatic test_reset();
        rst_ni          = 1'b0;
        bus.start_i     = 1'b0;
        bus.voice_idx_i = '0;
        bus.wave_i      = '0;
        bus.env_i       = '0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (bus.ready_o !== 1'b0) $display("FAIL reset_ready: got %b expected 0", bus.ready_o);
        else n_pass++;
        n_checks++;
        if (bus.prod_o !== 12'd0) $display("FAIL reset_prod: got %0d expected 0", bus.prod_o);
        else n_pass++;
        n_checks++;
        if (bus.mix_o !== 14'd0) $display("FAIL reset_mix: got %0d expected 0", bus.mix_o);
        else n_pass++;
        n_checks++;
        if (bus.mix_valid_o !== 1'b0) $display("FAIL reset_mix_valid: got %b expected 0", bus.mix_valid_o);
        else n_pass++;
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    // Runs a table of requests and compares each response to the scoreboard.
    task automatic test_ops(input string name, input int voices[], input int waves[],
                            input int envs[], input bit disturb);
        int lat, prod, mix, ep, em;
        bit extra, early, mv;
        for (int i = 0; i < voices.size(); i++) begin
            run_op(voices[i], waves[i], envs[i], disturb, lat, extra, early, prod, mv, mix);
            ep = exp_prod_q.pop_front();
            n_checks++;
            if (lat !== 9) $display("FAIL %s_latency[%0d]: got %0d expected 9", name, i, lat);
            else n_pass++;
            n_checks++;
            if (extra !== 1'b0) $display("FAIL %s_ready_width[%0d]: ready still high at T+10", name, i);
            else n_pass++;
            n_checks++;
            if (prod !== ep) $display("FAIL %s_prod[%0d]: got %0d expected %0d", name, i, prod, ep);
            else n_pass++;
            n_checks++;
            if (early !== 1'b0) $display("FAIL %s_mix_valid_early[%0d]: pulse before T+10", name, i);
            else n_pass++;
            n_checks++;
            if (mv !== (voices[i] == 2)) $display("FAIL %s_mix_valid[%0d]: got %b expected %b", name, i, mv, voices[i] == 2);
            else n_pass++;
            if (voices[i] == 2) begin
                em = exp_mix_q.pop_front();
                n_checks++;
                if (mix !== em) $display("FAIL %s_mix[%0d]: got %0d expected %0d", name, i, mix, em);
                else n_pass++;
            end
        end
    endtask

    task automatic test_full_scale();
        test_ops("full_scale", '{0}, '{2047}, '{255}, 1'b0);
    endtask

    task automatic test_corners();
        test_ops("corners", '{0, 0, 0}, '{-2048, -1, 1000}, '{255, 1, 0}, 1'b0);
    endtask

    task automatic test_frame();
        test_ops("frame", '{0, 1, 2, 0, 1, 2}, '{1024, -512, 2047, -300, 700, -2048},
                 '{128, 255, 64, 200, 100, 255}, 1'b0);
    endtask

    task automatic test_ignore_during_calc();
        test_ops("ignore", '{0, 1}, '{-777, 1500}, '{201, 99}, 1'b1);
    endtask

    task automatic test_voice3();
        test_ops("voice3", '{0, 1, 3, 2}, '{1024, -512, 1999, 2047}, '{128, 255, 177, 64}, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit seen_ready = 1'b0;
        bus.start_i     = 1'b1;
        bus.voice_idx_i = 2'd0;
        bus.wave_i      = 12'sd1234;
        bus.env_i       = 8'd200;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (bus.ready_o !== 1'b0) $display("FAIL midreset_ready: got %b expected 0", bus.ready_o);
        else n_pass++;
        n_checks++;
        if (bus.prod_o !== 12'd0) $display("FAIL midreset_prod: got %0d expected 0", bus.prod_o);
        else n_pass++;
        n_checks++;
        if (bus.mix_o !== 14'd0) $display("FAIL midreset_mix: got %0d expected 0", bus.mix_o);
        else n_pass++;
        model_mix = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (bus.ready_o) seen_ready = 1'b1;
        end
        n_checks++;
        if (seen_ready !== 1'b0) $display("FAIL midreset_no_ready: got 1 expected 0");
        else n_pass++;
        test_ops("after_reset", '{1, 2}, '{-1000, 600}, '{50, 250}, 1'b0);
    endtask

    task automatic test_back_to_back();
        int v[], w[], e[];
        v = new[6];
        w = new[6];
        e = new[6];
        for (int i = 0; i < 6; i++) begin
            v[i] = i % 3;
            w[i] = int'($urandom_range(4095)) - 2048;
            e[i] = int'($urandom_range(255));
        end
        test_ops("back_to_back", v, w, e, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_corners();
        test_frame();
        test_ignore_during_calc();
        test_voice3();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
